// File: rtl/elevator_motion_ctrl.sv
// Elevator motion/door controller: floor travel, door dwell, call clears.
// Optional door-hold input enabled by defining ELEV_DOOR_HOLD_EN.
module elevator_motion_ctrl #(
  parameter int FLOOR_CYCLES = 50000000,
  parameter int DOOR_CYCLES  = 100000000,
  parameter int CNT_W        = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] des,
  input  logic       des_valid,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic       door_hold,
`endif
  output logic [2:0] now_floor,
  output logic       dir,
  output logic       moving,
  output logic       door_open,
  output logic [5:0] clr_in,
  output logic [9:0] clr_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MOVE   = 2'd1;
  localparam logic [1:0] S_ARRIVE = 2'd2;
  localparam logic [1:0] S_DOOR   = 2'd3;

  localparam logic [CNT_W-1:0] FLOOR_LAST =
    CNT_W'(FLOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST =
    CNT_W'(DOOR_CYCLES - 1);

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       floor_n, step_floor;
  logic             dir_n;
  logic             hold;
  logic             des_ok;
  logic             beyond;
  logic [5:0]       clr_in_n;
  logic [9:0]       clr_out_n;

`ifdef ELEV_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  assign des_ok = des_valid && (des != 3'd0) && (des != 3'd7);

  // Next floor saturates at the shaft ends.
  always_comb begin
    step_floor = now_floor;
    if (dir && now_floor != 3'd6)
      step_floor = now_floor + 3'd1;
    else if (!dir && now_floor != 3'd1)
      step_floor = now_floor - 3'd1;
  end

  assign beyond = dir ? (des > step_floor)
                      : (des < step_floor);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    floor_n = now_floor;
    dir_n   = dir;
    unique case (1'b1)
      (state == S_IDLE): begin
        if (des_ok && des > now_floor) begin
          dir_n   = 1'b1;
          cnt_n   = '0;
          state_n = S_MOVE;
        end else if (des_ok && des < now_floor) begin
          dir_n   = 1'b0;
          cnt_n   = '0;
          state_n = S_MOVE;
        end else if (des_ok || hold) begin
          state_n = S_ARRIVE;
        end
      end
      (state == S_MOVE): begin
        if (cnt == FLOOR_LAST) begin
          cnt_n   = '0;
          floor_n = step_floor;
          if (des_ok && des == step_floor)
            state_n = S_ARRIVE;
          else if (!(des_ok && beyond))
            state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      (state == S_ARRIVE): begin
        cnt_n   = '0;
        state_n = S_DOOR;
      end
      (state == S_DOOR): begin
        if (hold) begin
          cnt_n = '0;
        end else if (cnt == DOOR_LAST) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Both hall calls of the arrival floor are cleared together.
  always_comb begin
    clr_in_n  = '0;
    clr_out_n = '0;
    if (state_n == S_ARRIVE) begin
      clr_in_n = 6'd1 << (floor_n - 3'd1);
      case (floor_n)
        3'd1:    clr_out_n = 10'b0000000001;
        3'd2:    clr_out_n = 10'b0000000110;
        3'd3:    clr_out_n = 10'b0000011000;
        3'd4:    clr_out_n = 10'b0001100000;
        3'd5:    clr_out_n = 10'b0110000000;
        3'd6:    clr_out_n = 10'b1000000000;
        default: clr_out_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      now_floor <= 3'd1;
      dir       <= 1'b1;
      moving    <= 1'b0;
      door_open <= 1'b0;
      clr_in    <= '0;
      clr_out   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      now_floor <= floor_n;
      dir       <= dir_n;
      moving    <= (state_n == S_MOVE);
      door_open <= (state_n == S_DOOR);
      clr_in    <= clr_in_n;
      clr_out   <= clr_out_n;
    end
  end

endmodule

// File: doc/elevator_motion_ctrl.md
Name: elevator_motion_ctrl

Overview:
- Motion/door controller sitting directly downstream of the destination-selection stage.
- Consumes the selected target floor and its valid flag.
- Owns and drives the current floor and travel direction back into the destination stage.
- Times floor-to-floor travel and door dwell, and pulses clear strobes to the call-latch registers on arrival.

Parameters:
- FLOOR_CYCLES, 50000000, clk cycles to travel one floor (>=2)
- DOOR_CYCLES, 100000000, clk cycles the door stays open (>=2)
- CNT_W, 27, counter width; must hold max(FLOOR_CYCLES, DOOR_CYCLES)-1

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- des  in  3  target floor from destination stage, 3'b001..3'b110 = floors 1..6
- des_valid  in  1  1 = at least one call pending, des meaningful
- now_floor  out  3  current floor, 3'b001..3'b110
- dir  out  1  1 = up, 0 = down; fed back to destination stage
- moving  out  1  1 while in MOVE
- door_open  out  1  1 while in DOOR
- clr_in  out  6  one-cycle clear strobe, bit f-1 = in-car button of floor f
- clr_out  out  10  one-cycle clear strobe for hall calls. Bit map: 0 = F1 up; 2k-3 = Fk down and 2k-2 = Fk up for k=2..5; 9 = F6 down.

Behaviour:
- Reset (async, rst_n=0): state IDLE, now_floor=3'b001, dir=1, moving=0, door_open=0, clr_in=0, clr_out=0, counter=0. Reset mid-move or mid-door aborts immediately to these values.
- All outputs are registered.
- des valid only when des_valid=1 and des in 1..6. des=0 or 7 is treated as des_valid=0.
- States: IDLE, MOVE, ARRIVE, DOOR.
- IDLE:
  - No valid des: stay in IDLE.
  - des>now_floor: dir<=1, cnt<=0, go MOVE.
  - des<now_floor: dir<=0, cnt<=0, go MOVE.
  - des==now_floor: go ARRIVE, dir unchanged.
- MOVE:
  - moving=1; cnt increments each cycle.
  - At cnt==FLOOR_CYCLES-1: now_floor<=now_floor±1 per dir, cnt<=0. Floor-to-floor time = FLOOR_CYCLES cycles.
  - At that same edge, des is compared with the new floor value:
    - equal: go ARRIVE.
    - des still beyond the new floor in direction dir: stay MOVE.
    - otherwise (reversal, or des_valid dropped): go IDLE, no door.
  - des changes between boundaries are ignored; des is only evaluated at floor boundaries.
  - Saturation: now_floor never passes 6 going up or 1 going down. Reaching 6 with dir=1, or 1 with dir=0, without a des match goes IDLE.
- ARRIVE (exactly one cycle):
  - clr_in[f-1]=1 for current floor f.
  - clr_out pulses both hall bits of floor f (only bit 0 for F1, only bit 9 for F6).
  - Next state DOOR, cnt<=0.
  - Clearing both hall calls prevents a stall when only the opposite-direction call is pending.
- DOOR:
  - door_open=1; cnt counts up.
  - At cnt==DOOR_CYCLES-1: go IDLE. door_open falls on that edge.
  - Calls arriving during DOOR are handled in IDLE afterwards.
- clr_* are zero in every state except ARRIVE.
- Latency:
  - des_valid seen in IDLE → moving=1 after 1 edge.
  - Arrival edge → clr strobe in the next cycle → door_open one edge later.
- The destination stage uses now_floor/dir registered outputs, so there is no combinational loop.

Optional Feature:
- Macro: ELEV_DOOR_HOLD_EN.
- With the macro defined:
  - Adds input port door_hold (1 bit, after des_valid).
  - door_hold=1 in DOOR resets cnt to 0, extending the open time.
  - door_hold=1 in IDLE with des==now_floor or no valid des goes ARRIVE, reopening the door at the current floor.
  - door_hold is ignored in MOVE and ARRIVE.
- Without the macro: port absent; behaviour exactly as above.

Test Plan (FLOOR_CYCLES=4, DOOR_CYCLES=3):
- Reset → now_floor=1, dir=1, moving=0, door_open=0, clr_in=0, clr_out=0; assert rst_n low mid-MOVE → same values asynchronously.
- From F1 idle, des=3, des_valid=1 at edge 0:
  - moving=1 after edge 0; now_floor=2 at edge 4, =3 at edge 8.
  - clr_in=6'b000100 and clr_out=10'b0000011000 for one cycle.
  - door_open=1 for 3 cycles; IDLE at edge 12.
- At F3, des=3 with des_valid=1 → no motion; ARRIVE strobe, then door_open=1 for 3 cycles.
- From F1 travelling to des=5, change des to 2 at cycle 2 → arrival at F2 (edge 4), clr_in=6'b000010, door opens.
- From F4 going up toward des=6, switch des to 1 before the F5 boundary → at F5 go IDLE with no door; next cycle dir=0, MOVE down.
- des=3'b000 or 3'b111 with des_valid=1 in IDLE → remains IDLE, no strobes.
- ELEV_DOOR_HOLD_EN: hold door_hold=1 for 5 cycles in DOOR → door_open stays 1 until 3 cycles after door_hold falls.
